// File: rtl/clm_key_scheduler_pkg.sv
// Shared CLM key-schedule types: masked state layout and key-schedule FSM encodings.
package clm_key_scheduler_pkg;

    localparam int unsigned D      = 4;
    localparam int unsigned ELEM_W = 8 + D;

    typedef logic [ELEM_W-1:0]  state_elem_t;
    typedef state_elem_t [3:0]  state_word_t;
    typedef state_word_t [3:0]  state_vec_t;

    typedef enum logic [1:0] {
        KS_STAGE_ROT,
        KS_STAGE_SUB,
        KS_STAGE_RCON,
        KS_STAGE_XOR
    } ks_stages_t;

    typedef enum logic [1:0] {
        KSC_IDLE,
        KSC_PRESENT,
        KSC_EXPAND,
        KSC_WAIT_KE
    } ks_ctrl_state_t;

endpackage

// File: rtl/clm_key_scheduler_register_word.sv
// One row of masked key state with a load enable; clears on asynchronous reset.
module register_word
    import clm_key_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  state_word_t next_word,
    output state_word_t word
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= '0;
        end else if (en) begin
            word <= next_word;
        end
    end

endmodule

// File: rtl/clm_key_scheduler.sv
// Round-key sequencer: presents the master key as round 0, then drives one
// key-expansion transaction per later round and offers each result to the consumer.
module clm_key_scheduler
    import clm_key_scheduler_pkg::*;
#(
    parameter int unsigned d  = 4,
    parameter int unsigned NR = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  state_vec_t key_in,
    output state_vec_t rk_out,
    output logic       rk_valid,
    input  logic       rk_ready,
    output logic [3:0] round_idx,
    output logic       last_round,
    output logic       busy,
    output state_vec_t ke_in,
    output logic       ke_drdy_i,
    output logic       ke_first_round,
    input  state_vec_t ke_out,
    input  logic       ke_drdy_o
);

    typedef logic [3:0][7+d:0] row_t;

    ks_ctrl_state_t state, state_next;
    state_vec_t     key_reg;
    row_t [3:0]     row_next;
    logic           load;
    logic           capture;

    assign load    = (state == KSC_IDLE) && start;
    assign capture = (state == KSC_WAIT_KE) && ke_drdy_o;

    // key_reg only moves on load or capture, so ke_in is stable for a whole expansion.
    for (genvar r = 0; r < 4; r++) begin : g_key_row
        assign row_next[r] = load ? key_in[r] : ke_out[r];

        register_word u_word (
            .clk       (clk),
            .rst       (rst),
            .en        (load | capture),
            .next_word (row_next[r]),
            .word      (key_reg[r])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= KSC_IDLE;
            round_idx <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                round_idx <= '0;
            end else if (capture) begin
                round_idx <= round_idx + 4'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        rk_valid   = 1'b0;
        ke_drdy_i  = 1'b0;
        case (state)
            KSC_IDLE: begin
                if (start) begin
                    state_next = KSC_PRESENT;
                end
            end
            KSC_PRESENT: begin
                rk_valid = 1'b1;
                if (rk_ready) begin
                    state_next = last_round ? KSC_IDLE : KSC_EXPAND;
                end
            end
            KSC_EXPAND: begin
                ke_drdy_i  = 1'b1;
                state_next = KSC_WAIT_KE;
            end
            KSC_WAIT_KE: begin
                if (ke_drdy_o) begin
                    state_next = KSC_PRESENT;
                end
            end
            default: state_next = KSC_IDLE;
        endcase
    end

    assign busy           = (state != KSC_IDLE);
    assign last_round     = (round_idx == 4'(NR));
    assign ke_first_round = busy && (round_idx == 4'd0);
    assign rk_out         = key_reg;
    assign ke_in          = key_reg;

endmodule

// File: tb/tb_clm_key_scheduler.sv
// Bench for clm_key_scheduler: an AES-style key-expansion responder plus a
// schedule model built from the whole key sequence computed up front.
module tb_clm_key_scheduler;
    import clm_key_scheduler_pkg::*;

    localparam int NR = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rk_ready = 1'b0;
    logic       ke_drdy_o = 1'b0;
    state_vec_t key_in = '0;
    state_vec_t ke_out = '0;
    state_vec_t rk_out, ke_in;
    logic       rk_valid, last_round, busy, ke_drdy_i, ke_first_round;
    logic [3:0] round_idx;

    always #5 clk = ~clk;

    clm_key_scheduler #(.d(4), .NR(NR)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .key_in         (key_in),
        .rk_out         (rk_out),
        .rk_valid       (rk_valid),
        .rk_ready       (rk_ready),
        .round_idx      (round_idx),
        .last_round     (last_round),
        .busy           (busy),
        .ke_in          (ke_in),
        .ke_drdy_i      (ke_drdy_i),
        .ke_first_round (ke_first_round),
        .ke_out         (ke_out),
        .ke_drdy_o      (ke_drdy_o)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  sbox [256];

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- AES key expansion arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] rcon_of(input int round);
        logic [7:0] rc = 8'h01;
        for (int j = 1; j < round; j++) rc = xtime(rc);
        return rc;
    endfunction

    // Byte i of the key sits at row i/4, column i%4, redundancy nibble zero.
    function automatic state_vec_t pack_key(input logic [127:0] k);
        state_vec_t v = '0;
        for (int i = 0; i < 16; i++) v[i/4][i%4] = {4'h0, k[127-8*i -: 8]};
        return v;
    endfunction

    function automatic logic [127:0] unpack_key(input state_vec_t v);
        logic [127:0] k = '0;
        for (int i = 0; i < 16; i++) k[127-8*i -: 8] = v[i/4][i%4][7:0];
        return k;
    endfunction

    function automatic state_vec_t rand_vec();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- schedule model ----------------
    state_vec_t ref_rk [NR+1];
    logic       m_busy = 1'b0, m_valid = 1'b0, m_pulse = 1'b0, m_wait = 1'b0;
    logic [3:0] m_idx = '0;
    state_vec_t m_key = '0;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_valid = 1'b0; m_pulse = 1'b0; m_wait = 1'b0;
            m_idx  = '0;   m_key   = '0;
        end
        check("rk_valid",       192'(rk_valid),       192'(m_valid));
        check("busy",           192'(busy),           192'(m_busy));
        check("ke_drdy_i",      192'(ke_drdy_i),      192'(m_pulse));
        check("round_idx",      192'(round_idx),      192'(m_idx));
        check("last_round",     192'(last_round),     192'(m_idx == 4'(NR)));
        check("ke_first_round", 192'(ke_first_round), 192'(m_busy && m_idx == 4'd0));
        check("rk_out",         rk_out,               m_key);
        check("ke_in",          ke_in,                m_key);
        if (!rst) begin
            if (!m_busy) begin
                if (start) begin
                    ref_rk[0] = key_in;
                    for (int i = 1; i <= NR; i++)
                        ref_rk[i] = pack_key(next_key(unpack_key(ref_rk[i-1]), rcon_of(i)));
                    m_busy = 1'b1; m_valid = 1'b1; m_idx = '0; m_key = key_in;
                end
            end else if (m_valid) begin
                if (rk_ready) begin
                    m_valid = 1'b0;
                    if (m_idx == 4'(NR)) m_busy = 1'b0;
                    else m_pulse = 1'b1;
                end
            end else if (m_pulse) begin
                m_pulse = 1'b0;
                m_wait  = 1'b1;
            end else if (m_wait && ke_drdy_o) begin
                m_wait  = 1'b0;
                m_idx   = m_idx + 4'd1;
                m_key   = ref_rk[m_idx];
                m_valid = 1'b1;
            end
        end
    end

    // ---------------- key-expansion responder ----------------
    logic         s_drdy_i = 1'b0, s_fr = 1'b0;
    state_vec_t   s_in = '0;
    logic         st_busy = 1'b0;
    int           st_cnt = 0;
    logic [7:0]   st_rcon = 8'h01;
    logic [127:0] st_res = '0;

    always @(negedge clk) begin
        s_drdy_i = ke_drdy_i;
        s_fr     = ke_first_round;
        s_in     = ke_in;
    end

    always @(posedge clk) begin
        #1;
        ke_drdy_o = 1'b0;
        if (rst) begin
            st_busy = 1'b0;
        end else if (st_busy) begin
            st_cnt--;
            if (st_cnt == 0) begin
                st_busy   = 1'b0;
                ke_drdy_o = 1'b1;
                ke_out    = pack_key(st_res);
            end
        end else if (s_drdy_i) begin
            st_rcon = s_fr ? 8'h01 : xtime(st_rcon);
            st_res  = next_key(unpack_key(s_in), st_rcon);
            st_busy = 1'b1;
            st_cnt  = int'($urandom_range(1, 4));
        end else if ($urandom_range(0, 7) == 0) begin
            // Stray result while no expansion is outstanding; must be ignored.
            ke_drdy_o = 1'b1;
            ke_out    = rand_vec();
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_key(input logic [3:0] idx, output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk);
            if (rk_valid && round_idx == idx) ok = 1'b1;
        end
    endtask

    initial begin
        logic         ok;
        logic [127:0] k;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        for (int i = 1; i <= NR; i++) begin
            k = next_key(k, rcon_of(i));
            if (i == 1)  check("model_round1",  192'(k), 192'(128'ha0fafe1788542cb123a339392a6c7605));
            if (i == NR) check("model_round10", 192'(k), 192'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        end

        // Reset held with start asserted; schedule begins only after release.
        start    = 1'b1;
        rk_ready = 1'b1;
        key_in   = pack_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;

        wait_key(4'd1, ok);
        check("timeout_round1", 192'(ok), 192'(1'b1));
        check("fips_round1", rk_out, pack_key(128'ha0fafe1788542cb123a339392a6c7605));
        wait_key(4'(NR), ok);
        check("timeout_round10", 192'(ok), 192'(1'b1));
        check("fips_round10", rk_out, pack_key(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        check("fips_last_round", 192'(last_round), 192'(1'b1));

        // Back-to-back restart: start raised alongside the final handshake.
        @(posedge clk);
        #1 start = 1'b1;
        key_in = rand_vec();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 start = 1'b0;

        // Consumer stall at round 3.
        wait_key(4'd3, ok);
        check("timeout_round3", 192'(ok), 192'(1'b1));
        @(posedge clk);
        #1 rk_ready = 1'b0;
        repeat (7) @(posedge clk);
        #1 rk_ready = 1'b1;

        // Asynchronous reset while round 4 expansion is outstanding.
        ok = 1'b0;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk);
            if (ke_drdy_i && round_idx == 4'd4) ok = 1'b1;
        end
        check("timeout_expand4", 192'(ok), 192'(1'b1));
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        start  = 1'b1;
        key_in = rand_vec();
        @(posedge clk);
        #1 start = 1'b0;
        wait_key(4'd1, ok);
        check("timeout_after_reset", 192'(ok), 192'(1'b1));

        // Randomised traffic with occasional mid-operation resets.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            start    = ($urandom_range(0, 9) == 0);
            key_in   = rand_vec();
            rk_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
